// File: rtl/aes_pkg.sv
// AES shared definitions: S-box, xtime/Rcon polynomial,
// key-length encodings and Nk/Nr lookups.
package aes_pkg;

  localparam int AES_MAX_WORDS = 60;
  localparam int AES_ADDR_W    = 4;

  localparam logic [7:0] RCON_POLY = 8'h1b;

  localparam logic [1:0] KEY_LEN_INV = 2'b00;
  localparam logic [1:0] KEY_LEN_128 = 2'b01;
  localparam logic [1:0] KEY_LEN_192 = 2'b10;
  localparam logic [1:0] KEY_LEN_256 = 2'b11;

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2*x^4*...*x^128), then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [3:0] nk_of(
    input logic [1:0] len
  );
    case (len)
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(
    input logic [1:0] len
  );
    case (len)
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: S-box applied to each byte of a word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {
    sbox(i_word[31:24]),
    sbox(i_word[23:16]),
    sbox(i_word[15:8]),
    sbox(i_word[7:0])
  };

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key schedule, one word per cycle, with
// round keys served as soon as their four words exist.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = AES_MAX_WORDS,
  parameter int ADDR_W    = AES_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [255:0]      key,
  input  logic [1:0]        key_len,
  input  logic              key_load,
  input  logic [ADDR_W-1:0] subkey_addr,
  output logic [127:0]      subkey,
  output logic              subkey_valid,
  output logic              busy,
  output logic              key_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic [31:0] r_temp;
  logic [31:0] r_w [MAX_WORDS];

  logic        w_load;
  logic [3:0]  w_load_nk;
  logic [31:0] w_load_last;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_f;
  logic [31:0] w_new;
  logic [5:0]  w_back;
  logic [5:0]  w_total;
  logic        w_last;
  logic        w_addr_ok;
  logic [6:0]  w_need;
  logic [5:0]  w_base;

  assign w_load    = key_load && (key_len != KEY_LEN_INV);
  assign w_load_nk = nk_of(key_len);

  always_comb begin
    w_load_last = key[159:128];
    case (key_len)
      KEY_LEN_192: w_load_last = key[95:64];
      KEY_LEN_256: w_load_last = key[31:0];
      default:     w_load_last = key[159:128];
    endcase
  end

  // RotWord only on the i%Nk==0 step; the AES-256 mid step
  // takes SubWord of temp unrotated.
  assign w_sub_in = (r_mod == 3'd0)
    ? {r_temp[23:0], r_temp[31:24]}
    : r_temp;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_f = r_temp;
    if (r_mod == 3'd0)
      w_f = w_sub_out ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_mod == 3'd4)
      w_f = w_sub_out;
  end

  assign w_back  = r_cnt - {2'b00, r_nk};
  assign w_new   = r_w[w_back] ^ w_f;
  assign w_total = {r_nr, 2'b00} + 6'd4;
  assign w_last  = (r_cnt == w_total - 6'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_nk    <= 4'd4;
      r_nr    <= 4'd0;
      r_mod   <= 3'd0;
      r_rcon  <= 8'h01;
      r_temp  <= 32'h0;
    end else if (w_load) begin
      r_state <= S_EXPAND;
      r_cnt   <= {2'b00, w_load_nk};
      r_nk    <= w_load_nk;
      r_nr    <= nr_of(key_len);
      r_mod   <= 3'd0;
      r_rcon  <= 8'h01;
      r_temp  <= w_load_last;
    end else if (r_state == S_EXPAND) begin
      r_temp <= w_new;
      r_cnt  <= r_cnt + 6'd1;
      r_mod  <= (r_mod == r_nk[2:0] - 3'd1)
        ? 3'd0 : r_mod + 3'd1;
      if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
      if (w_last) r_state <= S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(w_load_nk))
          r_w[j] <= key[255-32*j -: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[r_cnt] <= w_new;
    end
  end

  assign busy      = (r_state == S_EXPAND);
  assign key_ready = (r_state == S_DONE);

  assign w_addr_ok = (subkey_addr <= r_nr);
  assign w_need    = {1'b0, subkey_addr, 2'b00} + 7'd4;
  assign w_base    = w_addr_ok ? {subkey_addr, 2'b00} : 6'd0;

  assign subkey_valid = w_addr_ok
    && ({1'b0, r_cnt} >= w_need)
    && (busy || key_ready);

  assign subkey = subkey_valid
    ? {r_w[w_base],         r_w[w_base + 6'd1],
       r_w[w_base + 6'd2], r_w[w_base + 6'd3]}
    : 128'h0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 vectors.
`timescale 1ns/1ps
module tb_aes_key_expand;

  localparam logic [127:0] K128A =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    {128'h000102030405060708090a0b0c0d0e0f,
     128'h101112131415161718191a1b1c1d1e1f};

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         key_load;
  logic [3:0]   subkey_addr;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic         busy;
  logic         key_ready;

  int n_chk  = 0;
  int n_fail = 0;

  aes_key_expand dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_len      (key_len),
    .key_load     (key_load),
    .subkey_addr  (subkey_addr),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .busy         (busy),
    .key_ready    (key_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   len;
    int           lat;
    logic [3:0]   addr;
    logic [127:0] exp;
    logic [3:0]   bad;
  } vec_t;

  vec_t vecs [8];

  task automatic check(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load edge becomes cycle 0; inputs are scrambled afterwards.
  task automatic do_load(
    input logic [255:0] k,
    input logic [1:0]   len
  );
    key      = k;
    key_len  = len;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    key      = ~k;
    key_len  = 2'b11;
  endtask

  task automatic probe(input logic [3:0] a);
    subkey_addr = a;
    #1;
  endtask

  initial begin
    vecs[0] = '{{K128A, 128'h0}, 2'b01, 40, 4'd10,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd11};
    vecs[1] = '{{K128A, 128'h0}, 2'b01, 40, 4'd1,
      128'ha0fafe1788542cb123a339392a6c7605, 4'd11};
    vecs[2] = '{{K192, 64'h0}, 2'b10, 46, 4'd12,
      128'ha4970a331a78dc09c418c271e3a41d5d, 4'd13};
    vecs[3] = '{{K192, 64'h0}, 2'b10, 46, 4'd1,
      128'h10111213141516175846f2f95c43f4fe, 4'd13};
    vecs[4] = '{K256, 2'b11, 52, 4'd14,
      128'h24fc79ccbf0979e9371ac23c6d68de36, 4'd15};
    vecs[5] = '{K256, 2'b11, 52, 4'd2,
      128'ha573c29fa176c498a97fce93a572c09c, 4'd15};
    vecs[6] = '{{K128B, 128'h0}, 2'b01, 40, 4'd10,
      128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd11};
    vecs[7] = '{{K128B, 128'h0}, 2'b01, 40, 4'd1,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 4'd11};

    reset       = 1'b1;
    key         = '0;
    key_len     = 2'b00;
    key_load    = 1'b0;
    subkey_addr = 4'd0;
    step();
    step();
    check("rst_busy",  busy,         1'b0);
    check("rst_ready", key_ready,    1'b0);
    check("rst_valid", subkey_valid, 1'b0);
    check("rst_key",   subkey,       128'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      subkey_addr = 4'd0;
      do_load(vecs[v].key, vecs[v].len);
      check("r0_valid", subkey_valid, 1'b1);
      check("r0_key", subkey, vecs[v].key[255:128]);
      check("ld_ready", key_ready, 1'b0);
      for (int c = 1; c < vecs[v].lat; c++) step();
      check("pre_busy",  busy,      1'b1);
      check("pre_ready", key_ready, 1'b0);
      step();
      check("end_busy",  busy,      1'b0);
      check("end_ready", key_ready, 1'b1);
      probe(vecs[v].addr);
      check("vec_valid", subkey_valid, 1'b1);
      check("vec_key",   subkey,       vecs[v].exp);
      probe(vecs[v].bad);
      check("oob_valid", subkey_valid, 1'b0);
      check("oob_key",   subkey,       128'h0);
    end

    // Overlap: round k appears exactly 4k cycles after load.
    do_load({K128B, 128'h0}, 2'b01);
    for (int t = 0; t <= 41; t++) begin
      int k;
      k = t / 4;
      if (k > 10) k = 10;
      probe(4'(k));
      check("ovl_on", subkey_valid, 1'b1);
      if (k < 10) begin
        probe(4'(k + 1));
        check("ovl_off", subkey_valid, 1'b0);
      end
      if (t < 41) step();
    end
    probe(4'd10);
    check("ovl_key", subkey,
      128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Restart mid-expansion, then an ignored key_len=00 load.
    do_load(K256, 2'b11);
    for (int c = 1; c < 20; c++) step();
    probe(4'd1);
    check("rs_pre1", subkey_valid, 1'b1);
    do_load({K128A, 128'h0}, 2'b01);
    probe(4'd1);
    check("rs_drop1", subkey_valid, 1'b0);
    probe(4'd0);
    check("rs_r0", subkey, K128A);
    check("rs_busy", busy, 1'b1);
    for (int c = 1; c < 40; c++) step();
    check("rs_pre", key_ready, 1'b0);
    step();
    check("rs_ready", key_ready, 1'b1);
    probe(4'd10);
    check("rs_k10", subkey,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_load(K256, 2'b00);
    step();
    check("ign_ready", key_ready, 1'b1);
    check("ign_busy",  busy,      1'b0);
    check("ign_k10", subkey,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    probe(4'd0);
    check("ign_r0", subkey, K128A);

    // Asynchronous reset in the middle of an expansion.
    do_load({K128A, 128'h0}, 2'b01);
    for (int c = 1; c <= 10; c++) step();
    probe(4'd1);
    check("ar_pre", subkey_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_busy",  busy,         1'b0);
    check("ar_ready", key_ready,    1'b0);
    check("ar_valid", subkey_valid, 1'b0);
    check("ar_key",   subkey,       128'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    subkey_addr = 4'd0;
    do_load({K128A, 128'h0}, 2'b00);
    check("ar_ign_busy",  busy,         1'b0);
    check("ar_ign_valid", subkey_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
